// File: rtl/UART_pkg.sv
// Shared constants and command encoding for the UART command controller.
package UART_pkg;
  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 4;
  localparam int FUN_WIDTH     = 4;

  typedef enum logic [DATA_WIDTH-1:0] {
    CMD_WR      = 8'hAA,
    CMD_RD      = 8'hBB,
    CMD_ALU_OP  = 8'hCC,
    CMD_ALU_NOP = 8'hDD
  } cmd_e;

  // Register-file slots the ALU reads its operands from
  localparam logic [ADDRESS_WIDTH-1:0] ALU_A_ADDR = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] ALU_B_ADDR = ADDRESS_WIDTH'(1);
endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Byte sequencer toward UART TX: loads a 1- or 2-byte payload (LSB first),
// runs the valid/busy handshake per byte and pulses done_o when finished.
module sys_ctrl_tx_seq
  import UART_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start_i,
  input  logic                    two_i,
  input  logic [2*DATA_WIDTH-1:0] data_i,
  input  logic                    tx_busy_i,
  output logic [DATA_WIDTH-1:0]   tx_data_o,
  output logic                    tx_vld_o,
  output logic                    done_o
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} tx_state_e;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic                  more_q, more_d;
  logic                  vld_q, vld_d;
  logic                  done_q, done_d;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      hi_q    <= '0;
      more_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      hi_q    <= hi_d;
      more_q  <= more_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  // Handshake: hold valid until busy is seen, then wait for busy to clear
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    hi_d    = hi_q;
    more_d  = more_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        byte_d  = data_i[DATA_WIDTH-1:0];
        hi_d    = data_i[2*DATA_WIDTH-1:DATA_WIDTH];
        more_d  = two_i;
        vld_d   = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: if (tx_busy_i) begin
        vld_d   = 1'b0;
        state_d = S_HOLD;
      end
      S_HOLD: if (!tx_busy_i) begin
        if (more_q) begin
          byte_d  = hi_q;
          more_d  = 1'b0;
          vld_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data_o = byte_q;
  assign tx_vld_o  = vld_q;
  assign done_o    = done_q;
endmodule

// File: rtl/sys_ctrl.sv
// Command decoder between UART RX/TX and the register file / ALU.
// Frames: AA addr data | BB addr | CC A B fun | DD fun. All outputs registered.
module sys_ctrl
  import UART_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_valid,
  input  logic [2*DATA_WIDTH-1:0]  ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic                     TX_Busy,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT,
    ST_ALU_A, ST_ALU_B, ST_ALU_FUN, ST_ALU_WAIT, ST_TX
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;      // write address held between frame bytes
  logic [ADDRESS_WIDTH-1:0] adr_out_q, adr_out_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     wren_q, wren_d, rden_q, rden_d;
  logic                     alu_en_q, alu_en_d, clk_en_q, clk_en_d;
  logic [FUN_WIDTH-1:0]     fun_q, fun_d;
  logic [2*DATA_WIDTH-1:0]  res_q, res_d;        // payload for TX
  logic                     two_q, two_d, start_q, start_d;
  logic                     tx_done;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      adr_out_q <= '0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      fun_q     <= '0;
      res_q     <= '0;
      two_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      adr_out_q <= adr_out_d;
      wdata_q   <= wdata_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      fun_q     <= fun_d;
      res_q     <= res_d;
      two_q     <= two_d;
      start_q   <= start_d;
    end
  end

  // Frame decode; strobes default low so every enable is a single-cycle pulse
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    adr_out_d = adr_out_q;
    wdata_d   = wdata_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    alu_en_d  = 1'b0;
    clk_en_d  = clk_en_q;
    fun_d     = fun_q;
    res_d     = res_q;
    two_d     = two_q;
    start_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (RX_D_VLD) begin
        case (cmd_e'(RX_P_DATA))
          CMD_WR:      state_d = ST_WR_ADDR;
          CMD_RD:      state_d = ST_RD_ADDR;
          CMD_ALU_OP:  state_d = ST_ALU_A;
          CMD_ALU_NOP: state_d = ST_ALU_FUN;
          default:     state_d = ST_IDLE;
        endcase
      end
      ST_WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDRESS_WIDTH-1:0];
        state_d = ST_WR_DATA;
      end
      ST_WR_DATA: if (RX_D_VLD) begin
        adr_out_d = addr_q;
        wdata_d   = RX_P_DATA;
        wren_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_RD_ADDR: if (RX_D_VLD) begin
        adr_out_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
        rden_d    = 1'b1;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (RdData_valid) begin
        res_d   = {{DATA_WIDTH{1'b0}}, RdData};
        two_d   = 1'b0;
        start_d = 1'b1;
        state_d = ST_TX;
      end
      ST_ALU_A: if (RX_D_VLD) begin
        adr_out_d = ALU_A_ADDR;
        wdata_d   = RX_P_DATA;
        wren_d    = 1'b1;
        state_d   = ST_ALU_B;
      end
      ST_ALU_B: if (RX_D_VLD) begin
        adr_out_d = ALU_B_ADDR;
        wdata_d   = RX_P_DATA;
        wren_d    = 1'b1;
        state_d   = ST_ALU_FUN;
      end
      ST_ALU_FUN: if (RX_D_VLD) begin
        fun_d    = RX_P_DATA[FUN_WIDTH-1:0];
        alu_en_d = 1'b1;
        clk_en_d = 1'b1;
        state_d  = ST_ALU_WAIT;
      end
      ST_ALU_WAIT: if (OUT_Valid) begin
        res_d    = ALU_OUT;
        two_d    = 1'b1;
        clk_en_d = 1'b0;
        start_d  = 1'b1;
        state_d  = ST_TX;
      end
      ST_TX: if (tx_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  sys_ctrl_tx_seq u_tx_seq (
    .CLK       (CLK),
    .RST       (RST),
    .start_i   (start_q),
    .two_i     (two_q),
    .data_i    (res_q),
    .tx_busy_i (TX_Busy),
    .tx_data_o (TX_P_DATA),
    .tx_vld_o  (TX_D_VLD),
    .done_o    (tx_done)
  );

  assign Address = adr_out_q;
  assign WrEn    = wren_q;
  assign RdEn    = rden_q;
  assign WrData  = wdata_q;
  assign ALU_EN  = alu_en_q;
  assign ALU_FUN = fun_q;
  assign CLK_EN  = clk_en_q;
endmodule
